// File: rtl/psram_rx_capture_if.sv
// psram_rx_capture_if: capture control, psram pad inputs, read-word valid/ready port and status (master drives, slave is the capture stage)
interface psram_rx_capture_if #(parameter int FIFO_DEPTH = 4);
  logic start;
  logic [7:0] len;
  logic abort;
  logic psram_ce;
  logic psram_dqs_in;
  logic [7:0] psram_io_in;
  logic [31:0] rdata;
  logic rvalid;
  logic rready;
  logic rlast;
  logic busy;
  logic done;
  logic ovf;
  logic [$clog2(FIFO_DEPTH):0] level;
  modport master (
    output start, len, abort, psram_ce, psram_dqs_in, psram_io_in, rready,
    input rdata, rvalid, rlast, busy, done, ovf, level
  );
  modport slave (
    input start, len, abort, psram_ce, psram_dqs_in, psram_io_in, rready,
    output rdata, rvalid, rlast, busy, done, ovf, level
  );
endinterface

// File: rtl/psram_rx_capture.sv
// psram_rx_capture: DDR DQS capture of octal DQ into little-endian 32-bit words queued in a FIFO; ports clk, rst, bus (start/len/abort, psram ce/dqs/io in, rdata/rvalid/rready/rlast out port, busy/done/ovf/level status)
module psram_rx_capture #(
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  psram_rx_capture_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, CAPT, DONE} state_t;
  state_t state, state_nx;
  logic s1, s2, s3;
  logic [7:0] d1, d2;
  logic [7:0] rem;
  logic [1:0] idx;
  logic [23:0] pack;
  logic ovf;
  logic [32:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic ev, take, last_byte, push, pop, full, wr, rvalid;
  logic [31:0] word;
  always_ff @(posedge clk) begin
    if (rst) begin
      {s1, s2, s3} <= '0;
      d1 <= '0;
      d2 <= '0;
    end else begin
      s1 <= bus.psram_dqs_in;
      s2 <= s1;
      s3 <= s2;
      d1 <= bus.psram_io_in;
      d2 <= d1;
    end
  end
  always_comb begin
    ev = (s2 ^ s3) & ~bus.psram_ce;
    take = state == CAPT && ev && !bus.abort;
    last_byte = rem == 8'd1;
    push = take && (idx == 2'd3 || last_byte);
    word = {8'b0, pack} | (32'(d2) << {idx, 3'b000});
    rvalid = cnt != '0;
    pop = rvalid && bus.rready;
    full = cnt == (AW+1)'(FIFO_DEPTH);
    wr = push && (!full || pop);
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  always_comb begin
    state_nx = state == IDLE ? (bus.start ? (bus.len != 8'd0 ? CAPT : DONE) : IDLE)
             : state == CAPT ? ((bus.abort || (push && last_byte)) ? DONE : CAPT)
             : IDLE;
  end
  always_comb begin
    bus.busy = state == CAPT;
    bus.done = state == DONE;
    bus.rvalid = rvalid;
    bus.rdata = rvalid ? mem[rp][31:0] : '0;
    bus.rlast = rvalid && mem[rp][32];
    bus.level = cnt;
    bus.ovf = ovf;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rem <= '0;
      idx <= '0;
      pack <= '0;
      ovf <= 1'b0;
    end else begin
      if (state == IDLE && bus.start) begin
        rem <= bus.len;
        idx <= '0;
        pack <= '0;
        ovf <= 1'b0;
      end else if (state == CAPT && bus.abort) begin
        idx <= '0;
        pack <= '0;
      end else if (take) begin
        rem <= rem - 8'd1;
        idx <= idx + 2'd1;
        pack <= push ? '0 : word[23:0];
      end
      if (push && full && !pop) ovf <= 1'b1;
    end
  end
  always_ff @(posedge clk) if (wr) mem[wp] <= {last_byte, word};
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (wr) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(pop);
    end
  end
endmodule

// File: tb/tb_psram_rx_capture.sv
// tb_psram_rx_capture: scoreboard bench for psram_rx_capture covering packing, overflow, abort, empty capture and reset
module tb_psram_rx_capture;
  localparam int D = 4;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  psram_rx_capture_if #(.FIFO_DEPTH(D)) bus();
  psram_rx_capture #(.FIFO_DEPTH(D)) dut (.clk(clk), .rst(rst), .bus(bus));
  int vectors = 0;
  int miscompares = 0;
  logic [32:0] sb[$];
  logic [32:0] e;
  int mlev = 0;
  int done_cnt = 0;
  int d0;
  bit busy_seen = 0;
  bit in_cap = 0;
  int mrem = 0;
  int mlane = 0;
  logic [31:0] mcur = 0;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.done) done_cnt++;
      if (bus.busy) busy_seen = 1;
      if (bus.rvalid && bus.rready) begin
        if (sb.size() == 0) check("unexpected_pop", 1, 0);
        else begin
          e = sb.pop_front();
          check("rdata", bus.rdata, e[31:0]);
          check("rlast", bus.rlast, e[32]);
          mlev--;
        end
      end else if (!bus.rvalid) check("empty_head", {bus.rlast, bus.rdata}, 0);
    end
  end
  task automatic model_byte(input logic [7:0] b, input bit popw);
    mcur |= 32'(b) << (8 * mlane);
    mlane++;
    mrem--;
    if (mlane == 4 || mrem == 0) begin
      if (!(mlev == D && !popw)) begin
        sb.push_back({(mrem == 0), mcur});
        mlev++;
      end
      mcur = 0;
      mlane = 0;
      if (mrem == 0) in_cap = 0;
    end
  endtask
  task automatic send(input logic [7:0] b, input bit ce_low = 1, input bit popw = 0);
    bus.psram_io_in = b;
    bus.psram_ce = !ce_low;
    bus.psram_dqs_in = !bus.psram_dqs_in;
    if (ce_low && in_cap) model_byte(b, popw);
    repeat (2) @(posedge clk);
    #1;
    if (popw) bus.rready = 1;
    @(posedge clk);
    #1;
    if (popw) bus.rready = 0;
  endtask
  task automatic start_cap(input logic [7:0] l);
    bus.start = 1;
    bus.len = l;
    mrem = l;
    mlane = 0;
    mcur = 0;
    in_cap = l != 0;
    @(posedge clk);
    #1;
    bus.start = 0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_rdata"}, bus.rdata, 0);
    check({tag, "_rvalid"}, bus.rvalid, 0);
    check({tag, "_rlast"}, bus.rlast, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_ovf"}, bus.ovf, 0);
    check({tag, "_level"}, bus.level, 0);
  endtask
  initial begin
    bus.start = 0;
    bus.len = 0;
    bus.abort = 0;
    bus.psram_ce = 1;
    bus.psram_dqs_in = 0;
    bus.psram_io_in = 0;
    bus.rready = 0;
    idle(3);
    check_zero("reset");
    rst = 0;
    bus.rready = 1;
    send(8'hAA);
    send(8'hBB);
    idle(3);
    check("idle_level", bus.level, 0);
    d0 = done_cnt;
    start_cap(4);
    check("busy", bus.busy, 1);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    send(8'h44);
    check("rvalid_lat", bus.rvalid, 1);
    check("done_lat", bus.done, 1);
    idle(1);
    check("done_pulse", bus.done, 0);
    check("busy_end", bus.busy, 0);
    check("done4_cnt", done_cnt - d0, 1);
    idle(3);
    d0 = done_cnt;
    start_cap(6);
    for (int i = 1; i <= 6; i++) send(8'(i));
    idle(4);
    check("done6_cnt", done_cnt - d0, 1);
    d0 = done_cnt;
    start_cap(8);
    send(8'h01);
    send(8'hE1, 0);
    send(8'h02);
    send(8'h03);
    send(8'hE2, 0);
    send(8'h04);
    send(8'h05);
    send(8'h06);
    bus.abort = 1;
    in_cap = 0;
    idle(1);
    bus.abort = 0;
    check("abort_done", bus.done, 1);
    idle(4);
    check("abort_level", bus.level, 0);
    check("abort_sb", sb.size(), 0);
    check("abort_done_cnt", done_cnt - d0, 1);
    busy_seen = 0;
    d0 = done_cnt;
    start_cap(0);
    check("empty_done", bus.done, 1);
    check("empty_busy", bus.busy, 0);
    idle(1);
    check("empty_done_end", bus.done, 0);
    check("empty_level", bus.level, 0);
    check("empty_busy_seen", busy_seen, 0);
    check("empty_done_cnt", done_cnt - d0, 1);
    bus.rready = 0;
    d0 = done_cnt;
    start_cap(20);
    for (int i = 0; i < 20; i++) send(8'h40 + 8'(i));
    check("ovf_level", bus.level, 4);
    check("ovf_flag", bus.ovf, 1);
    idle(2);
    check("ovf_done_cnt", done_cnt - d0, 1);
    bus.rready = 1;
    idle(8);
    check("ovf_drain", sb.size(), 0);
    check("ovf_drain_level", bus.level, 0);
    bus.rready = 0;
    start_cap(20);
    check("ovf_clear", bus.ovf, 0);
    for (int i = 0; i < 20; i++) send(8'h60 + 8'(i), 1, i == 19);
    check("pp_level", bus.level, 4);
    check("pp_ovf", bus.ovf, 0);
    bus.rready = 1;
    idle(8);
    check("pp_drain", sb.size(), 0);
    bus.rready = 0;
    start_cap(8);
    for (int i = 0; i < 7; i++) send(8'hA0 + 8'(i));
    check("mid_level", bus.level, 1);
    rst = 1;
    idle(1);
    check_zero("mid_rst");
    rst = 0;
    sb.delete();
    mlev = 0;
    in_cap = 0;
    idle(4);
    bus.rready = 1;
    start_cap(4);
    send(8'hDE);
    send(8'hAD);
    send(8'hBE);
    send(8'hEF);
    check("post_rst_rvalid", bus.rvalid, 1);
    idle(3);
    check("post_rst_sb", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
